// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port unified memory (fetch vs data).
// Ports: clock/reset_, if_* fetch port, d_* data port, m_* memory port, bus_err, stall.
module mem_arbiter #(
    parameter int unsigned FAIR_LIMIT = 4,
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic        clock,
    input  logic        reset_,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        bus_err,
    output logic        stall
);

    localparam int FW = $clog2(FAIR_LIMIT + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DBUS,
        IBUS,
        RESP
    } state_t;

    state_t        state;
    logic [FW-1:0] fair_cnt;
    logic [WW-1:0] wait_cnt;

    logic        fair_ok;
    logic        grant_d;
    logic        grant_i;
    logic [31:0] sel_addr;
    logic        timed_out;
    logic        done;

    // Data wins unless the fetch has been starved FAIR_LIMIT times in a row.
    assign fair_ok   = (fair_cnt < FW'(FAIR_LIMIT));
    assign grant_d   = d_req & (~if_req | fair_ok);
    assign grant_i   = if_req & ~grant_d;
    assign sel_addr  = grant_d ? d_addr : if_addr;

    // A ready strobe in the final wait cycle still completes normally.
    assign done      = m_ready;
    assign timed_out = ~m_ready & (wait_cnt == WW'(TIMEOUT - 1));

    assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            state    <= IDLE;
            fair_cnt <= '0;
            wait_cnt <= '0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            bus_err  <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
        end else begin
            if_ack  <= 1'b0;
            d_ack   <= 1'b0;
            bus_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Only a data grant over a waiting fetch counts as unfair.
                    if (if_req && grant_d) begin
                        fair_cnt <= fair_cnt + FW'(1);
                    end else begin
                        fair_cnt <= '0;
                    end
                    if (grant_d || grant_i) begin
                        wait_cnt <= '0;
                        m_req    <= 1'b1;
                        m_we     <= grant_d & d_we;
                        m_addr   <= sel_addr & ~32'h3;
                        m_wdata  <= grant_d ? d_wdata : '0;
                        state    <= grant_d ? DBUS : IBUS;
                    end
                end
                DBUS: begin
                    if (done) begin
                        m_req <= 1'b0;
                        d_ack <= 1'b1;
                        if (!m_we) begin
                            d_rdata <= m_rdata;
                        end
                        state <= RESP;
                    end else if (timed_out) begin
                        m_req   <= 1'b0;
                        d_ack   <= 1'b1;
                        bus_err <= 1'b1;
                        if (!m_we) begin
                            d_rdata <= ERR_DATA;
                        end
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                IBUS: begin
                    if (done) begin
                        m_req    <= 1'b0;
                        if_ack   <= 1'b1;
                        if_rdata <= m_rdata;
                        state    <= RESP;
                    end else if (timed_out) begin
                        m_req    <= 1'b0;
                        if_ack   <= 1'b1;
                        bus_err  <= 1'b1;
                        if_rdata <= ERR_DATA;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                RESP: begin
                    // Ack is visible this cycle; no grant until IDLE.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Memory model answers in the first bus cycle when mem_en is set.
module tb_mem_arbiter;

    logic        clock;
    logic        reset_;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        bus_err;
    logic        stall;

    logic        mem_en;
    logic [31:0] mem_data;

    int checks;
    int errors;

    mem_arbiter dut (
        .clock    (clock),
        .reset_   (reset_),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready),
        .bus_err  (bus_err),
        .stall    (stall)
    );

    assign m_ready = m_req & mem_en;
    assign m_rdata = mem_data;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int cnt;
        int dacks;
        int ack_cyc;
        checks   = 0;
        errors   = 0;
        reset_   = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        mem_en   = 1'b0;
        mem_data = '0;

        step();
        step();
        chk("rst_m_req", {31'd0, m_req}, 32'd0);
        chk("rst_acks", {29'd0, if_ack, d_ack, bus_err}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        reset_ = 1'b0;
        step();

        // single load
        d_we     = 1'b0;
        d_addr   = 32'h0000_0104;
        mem_data = 32'h1234_5678;
        mem_en   = 1'b1;
        d_req    = 1'b1;
        #1;
        chk("ld_stall_c0", {31'd0, stall}, 32'd1);
        step();
        chk("ld_m_req", {31'd0, m_req}, 32'd1);
        chk("ld_m_addr", m_addr, 32'h0000_0104);
        chk("ld_m_we", {31'd0, m_we}, 32'd0);
        chk("ld_no_ack_c1", {31'd0, d_ack}, 32'd0);
        chk("ld_stall_c1", {31'd0, stall}, 32'd1);
        step();
        chk("ld_ack", {31'd0, d_ack}, 32'd1);
        chk("ld_rdata", d_rdata, 32'h1234_5678);
        chk("ld_m_req_drop", {31'd0, m_req}, 32'd0);
        chk("ld_stall_ack", {31'd0, stall}, 32'd0);
        d_req = 1'b0;
        step();
        chk("ld_ack_pulse", {31'd0, d_ack}, 32'd0);

        // simultaneous requests: data first
        if_req   = 1'b1;
        if_addr  = 32'h0000_0040;
        d_req    = 1'b1;
        d_addr   = 32'h0000_0080;
        mem_data = 32'hAAAA_0001;
        step();
        chk("sim_data_first", m_addr, 32'h0000_0080);
        step();
        chk("sim_d_ack", {31'd0, d_ack}, 32'd1);
        chk("sim_if_wait", {31'd0, if_ack}, 32'd0);
        chk("sim_d_rdata", d_rdata, 32'hAAAA_0001);
        d_req    = 1'b0;
        mem_data = 32'hBBBB_0002;
        step();
        chk("sim_idle_c3", {31'd0, m_req}, 32'd0);
        step();
        chk("sim_if_m_req", {31'd0, m_req}, 32'd1);
        chk("sim_if_addr", m_addr, 32'h0000_0040);
        step();
        chk("sim_if_ack_c5", {31'd0, if_ack}, 32'd1);
        chk("sim_if_rdata", if_rdata, 32'hBBBB_0002);
        if_req = 1'b0;
        step();

        // fairness: four data grants then the fetch
        mem_data = 32'h5555_AAAA;
        if_addr  = 32'h0000_0300;
        d_addr   = 32'h0000_0090;
        d_we     = 1'b0;
        if_req   = 1'b1;
        d_req    = 1'b1;
        dacks    = 0;
        ack_cyc  = -1;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (c == 11) begin
                chk("fair_at_limit", 32'(dut.fair_cnt), 32'd4);
            end
            if (d_ack) dacks++;
            if (if_ack) begin
                ack_cyc = c;
                break;
            end
        end
        chk("fair_dacks", dacks, 32'd4);
        chk("fair_if_ack_cyc", ack_cyc, 32'd14);
        chk("fair_cleared", 32'(dut.fair_cnt), 32'd0);
        if_req = 1'b0;
        d_req  = 1'b0;
        step();

        // store
        d_we    = 1'b1;
        d_addr  = 32'h0000_0203;
        d_wdata = 32'hA5A5_A5A5;
        d_req   = 1'b1;
        step();
        chk("st_m_addr", m_addr, 32'h0000_0200);
        chk("st_m_we", {31'd0, m_we}, 32'd1);
        chk("st_m_wdata", m_wdata, 32'hA5A5_A5A5);
        step();
        chk("st_ack", {31'd0, d_ack}, 32'd1);
        chk("st_rdata_kept", d_rdata, 32'h5555_AAAA);
        d_req = 1'b0;
        d_we  = 1'b0;
        step();

        // fetch timeout
        mem_en  = 1'b0;
        if_addr = 32'h0000_0500;
        if_req  = 1'b1;
        cnt     = 0;
        for (int c = 1; c <= 400; c++) begin
            step();
            if (if_ack) break;
            if (m_req) cnt++;
        end
        chk("to_ack", {31'd0, if_ack}, 32'd1);
        chk("to_m_req_cycles", cnt, 32'd255);
        chk("to_bus_err", {31'd0, bus_err}, 32'd1);
        chk("to_err_data", if_rdata, 32'hDEAD_BEEF);
        chk("to_m_req_drop", {31'd0, m_req}, 32'd0);
        if_req = 1'b0;
        mem_en = 1'b1;
        step();
        chk("to_err_pulse", {31'd0, bus_err}, 32'd0);
        if_addr  = 32'h0000_0600;
        mem_data = 32'h600D_0600;
        if_req   = 1'b1;
        step();
        step();
        chk("post_to_ack", {31'd0, if_ack}, 32'd1);
        chk("post_to_no_err", {31'd0, bus_err}, 32'd0);
        chk("post_to_rdata", if_rdata, 32'h600D_0600);
        if_req = 1'b0;
        step();

        // reset while waiting on memory
        mem_en = 1'b0;
        d_addr = 32'h0000_0700;
        d_req  = 1'b1;
        step();
        chk("mid_m_req", {31'd0, m_req}, 32'd1);
        #2;
        reset_ = 1'b1;
        d_req  = 1'b0;
        #1;
        chk("mid_m_req_drop", {31'd0, m_req}, 32'd0);
        chk("mid_m_addr", m_addr, 32'd0);
        chk("mid_if_rdata", if_rdata, 32'd0);
        chk("mid_d_rdata", d_rdata, 32'd0);
        chk("mid_acks", {29'd0, if_ack, d_ack, bus_err}, 32'd0);
        step();
        chk("mid_no_ack", {31'd0, d_ack}, 32'd0);
        reset_ = 1'b0;
        step();
        mem_en   = 1'b1;
        mem_data = 32'h0BAD_CAFE;
        d_addr   = 32'h0000_0704;
        d_req    = 1'b1;
        step();
        step();
        chk("rel_ack", {31'd0, d_ack}, 32'd1);
        chk("rel_rdata", d_rdata, 32'h0BAD_CAFE);
        d_req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
